// File: rtl/sdio_cmd_sequencer.sv
// SDIO command-layer sequencer: tracks card state, answers CMD0/3/5/7/52 and
// runs CMD52 accesses on a single-beat register bus with a bounded wait.
module sdio_cmd_sequencer #(
    parameter logic [2:0]  NUM_FUNCS   = 3'd1,
    parameter logic [23:0] OCR_VALUE   = 24'hFF8000,
    parameter logic [15:0] RCA_VALUE   = 16'h0001,
    parameter logic [7:0]  REG_TIMEOUT = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_crc_good_stb,
    input  logic [5:0]  i_cmd,
    input  logic [31:0] i_cmd_arg,
    output logic        o_rsps_stb,
    output logic [39:0] o_rsps,
    output logic [7:0]  o_rsps_len,
    output logic        o_rsps_fail,
    output logic        o_reg_stb,
    output logic        o_reg_wr,
    output logic [2:0]  o_reg_func,
    output logic [16:0] o_reg_addr,
    output logic [7:0]  o_reg_data,
    input  logic        i_reg_ack,
    input  logic [7:0]  i_reg_data,
    output logic [1:0]  o_card_state,
    output logic        o_busy,
    output logic        o_cmd_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_REG_REQ, S_REG_WAIT, S_RESPOND
    } state_t;

    localparam logic [1:0] CARD_INIT = 2'd0;
    localparam logic [1:0] CARD_STBY = 2'd1;
    localparam logic [1:0] CARD_CMD  = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  card_q, card_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic        crc_ok_q, crc_ok_d;
    logic [39:0] rsps_q, rsps_d;
    logic        rsps_stb_q, rsps_stb_d;
    logic        rsps_fail_q, rsps_fail_d;
    logic        reg_stb_q, reg_stb_d;
    logic        reg_wr_q, reg_wr_d;
    logic [2:0]  reg_func_q, reg_func_d;
    logic [16:0] reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        drop_q, drop_d;

    function automatic logic [39:0] r5_word(input logic [7:0] flags, input logic [7:0] data);
        return {2'b00, 6'd52, 16'h0000, flags, data};
    endfunction

    always_comb begin
        state_d     = state_q;
        card_d      = card_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        crc_ok_d    = crc_ok_q;
        rsps_d      = rsps_q;
        rsps_stb_d  = 1'b0;
        rsps_fail_d = 1'b0;
        reg_stb_d   = 1'b0;
        reg_wr_d    = reg_wr_q;
        reg_func_d  = reg_func_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        cnt_d       = cnt_q;
        drop_d      = i_cmd_stb && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (i_cmd_stb) begin
                    cmd_d    = i_cmd;
                    arg_d    = i_cmd_arg;
                    crc_ok_d = i_cmd_crc_good_stb;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_RESPOND;
                if (!crc_ok_q) begin
                    rsps_fail_d = 1'b1;
                end else begin
                    case (cmd_q)
                        6'd0: begin
                            card_d      = CARD_INIT;
                            rsps_fail_d = 1'b1;
                        end
                        6'd5: begin
                            rsps_d     = {2'b00, 6'h3F, 1'b1, NUM_FUNCS, 1'b0, 3'b000, OCR_VALUE};
                            rsps_stb_d = 1'b1;
                            if ((arg_q[23:0] != 24'd0) && (card_q == CARD_INIT))
                                card_d = CARD_STBY;
                        end
                        6'd3: begin
                            if (card_q != CARD_INIT) begin
                                rsps_d     = {2'b00, 6'd3, RCA_VALUE, 16'h0000};
                                rsps_stb_d = 1'b1;
                            end else begin
                                rsps_fail_d = 1'b1;
                            end
                        end
                        6'd7: begin
                            if (card_q == CARD_INIT) begin
                                rsps_fail_d = 1'b1;
                            end else if (arg_q[31:16] == RCA_VALUE) begin
                                rsps_d     = {2'b00, 6'd7, 32'h0};
                                rsps_stb_d = 1'b1;
                                card_d     = CARD_CMD;
                            end else begin
                                card_d      = CARD_STBY;
                                rsps_fail_d = 1'b1;
                            end
                        end
                        6'd52: begin
                            if (card_q != CARD_CMD) begin
                                rsps_fail_d = 1'b1;
                            end else if (arg_q[30:28] > NUM_FUNCS) begin
                                rsps_d     = r5_word(8'h12, 8'h00);
                                rsps_stb_d = 1'b1;
                            end else begin
                                state_d    = S_REG_REQ;
                                reg_stb_d  = 1'b1;
                                reg_wr_d   = arg_q[31];
                                reg_func_d = arg_q[30:28];
                                reg_addr_d = arg_q[25:9];
                                reg_data_d = arg_q[7:0];
                            end
                        end
                        default: rsps_fail_d = 1'b1;
                    endcase
                end
            end
            S_REG_REQ: begin
                state_d = S_REG_WAIT;
                cnt_d   = 8'd0;
            end
            S_REG_WAIT: begin
                // An ack on the final waiting cycle takes priority over the timeout.
                if (i_reg_ack) begin
                    rsps_d     = r5_word(8'h10, (!arg_q[31] || arg_q[27]) ? i_reg_data : arg_q[7:0]);
                    rsps_stb_d = 1'b1;
                    state_d    = S_RESPOND;
                end else if (cnt_q + 8'd1 == REG_TIMEOUT) begin
                    rsps_d     = r5_word(8'h18, 8'h00);
                    rsps_stb_d = 1'b1;
                    state_d    = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            card_q      <= CARD_INIT;
            cmd_q       <= 6'd0;
            arg_q       <= 32'd0;
            crc_ok_q    <= 1'b0;
            rsps_q      <= 40'd0;
            rsps_stb_q  <= 1'b0;
            rsps_fail_q <= 1'b0;
            reg_stb_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_func_q  <= 3'd0;
            reg_addr_q  <= 17'd0;
            reg_data_q  <= 8'd0;
            cnt_q       <= 8'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_q      <= card_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            crc_ok_q    <= crc_ok_d;
            rsps_q      <= rsps_d;
            rsps_stb_q  <= rsps_stb_d;
            rsps_fail_q <= rsps_fail_d;
            reg_stb_q   <= reg_stb_d;
            reg_wr_q    <= reg_wr_d;
            reg_func_q  <= reg_func_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign o_rsps_stb   = rsps_stb_q;
    assign o_rsps       = rsps_q;
    assign o_rsps_len   = 8'd40;
    assign o_rsps_fail  = rsps_fail_q;
    assign o_reg_stb    = reg_stb_q;
    assign o_reg_wr     = reg_wr_q;
    assign o_reg_func   = reg_func_q;
    assign o_reg_addr   = reg_addr_q;
    assign o_reg_data   = reg_data_q;
    assign o_card_state = card_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_cmd_drop   = drop_q;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Self-checking bench for sdio_cmd_sequencer: directed scenarios plus a
// randomized command stream compared against a behavioural card model.
module tb_sdio_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_stb = 1'b0;
    logic        i_cmd_crc_good_stb = 1'b0;
    logic [5:0]  i_cmd = '0;
    logic [31:0] i_cmd_arg = '0;
    logic        o_rsps_stb;
    logic [39:0] o_rsps;
    logic [7:0]  o_rsps_len;
    logic        o_rsps_fail;
    logic        o_reg_stb;
    logic        o_reg_wr;
    logic [2:0]  o_reg_func;
    logic [16:0] o_reg_addr;
    logic [7:0]  o_reg_data;
    logic        i_reg_ack = 1'b0;
    logic [7:0]  i_reg_data = '0;
    logic [1:0]  o_card_state;
    logic        o_busy;
    logic        o_cmd_drop;

    int checks = 0;
    int errors = 0;

    // observations from run_simple
    logic        obs_busy1, obs_early, obs_stb, obs_fail, obs_regstb, obs_busy3, obs_after;
    logic [39:0] obs_rsps;
    logic [1:0]  obs_card;

    // model state
    logic [1:0]  m_card = 2'd0;
    logic [39:0] m_rsps = 40'd0;

    sdio_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .i_cmd_stb(i_cmd_stb), .i_cmd_crc_good_stb(i_cmd_crc_good_stb),
        .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg),
        .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_len(o_rsps_len),
        .o_rsps_fail(o_rsps_fail),
        .o_reg_stb(o_reg_stb), .o_reg_wr(o_reg_wr), .o_reg_func(o_reg_func),
        .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data),
        .i_reg_ack(i_reg_ack), .i_reg_data(i_reg_data),
        .o_card_state(o_card_state), .o_busy(o_busy), .o_cmd_drop(o_cmd_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Card model: kind 0 = response, 1 = fail, 2 = register access
    function automatic void model_cmd(input logic [1:0] st, input logic [5:0] c, input logic [31:0] a,
                                      input logic good, output int kind, output logic [39:0] rsp,
                                      output logic [1:0] nst);
        nst = st; rsp = 40'd0; kind = 1;
        if (!good) return;
        case (c)
            6'd0:  nst = 2'd0;
            6'd5: begin
                kind = 0; rsp = 40'h3F90FF8000;
                if (a[23:0] != 0 && st == 2'd0) nst = 2'd1;
            end
            6'd3:  if (st != 2'd0) begin kind = 0; rsp = 40'h0300010000; end
            6'd7:  if (st != 2'd0) begin
                if (a[31:16] == 16'h0001) begin kind = 0; rsp = 40'h0700000000; nst = 2'd2; end
                else nst = 2'd1;
            end
            6'd52: if (st == 2'd2) begin
                if (a[30:28] > 3'd1) begin kind = 0; rsp = 40'h3400001200; end
                else kind = 2;
            end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic good);
        @(posedge clk); #1;
        i_cmd_stb = 1'b1; i_cmd = c; i_cmd_arg = a; i_cmd_crc_good_stb = good;
        @(posedge clk); #1;
        i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
    endtask

    task automatic run_simple(input logic [5:0] c, input logic [31:0] a, input logic good);
        issue(c, a, good);
        obs_busy1 = o_busy; obs_early = o_rsps_stb | o_rsps_fail;
        @(posedge clk); #1;
        obs_stb = o_rsps_stb; obs_fail = o_rsps_fail; obs_rsps = o_rsps;
        obs_card = o_card_state; obs_regstb = o_reg_stb;
        @(posedge clk); #1;
        obs_busy3 = o_busy; obs_after = o_rsps_stb | o_rsps_fail;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({o_rsps_stb, o_rsps_fail, o_busy, o_cmd_drop} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000", {o_rsps_stb, o_rsps_fail, o_busy, o_cmd_drop});
        end
        checks++;
        if (o_rsps !== 40'd0 || o_rsps_len !== 8'd40) begin
            errors++; $display("FAIL reset_rsps: got rsps=%h len=%0d want 0/40", o_rsps, o_rsps_len);
        end
        checks++;
        if ({o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr, o_reg_data} !== 30'd0 || o_card_state !== 2'd0) begin
            errors++; $display("FAIL reset_reg_card: got reg=%h card=%0d want 0/0",
                               {o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr, o_reg_data}, o_card_state);
        end
        m_card = 2'd0; m_rsps = 40'd0;
    endtask

    task automatic test_init_sequence;
        logic [31:0] args [5];
        logic [5:0]  cmds [5];
        logic        exp_stb [5];
        logic [39:0] exp_rsp [5];
        logic [1:0]  exp_card [5];
        cmds = '{6'd5, 6'd5, 6'd3, 6'd7, 6'd7};
        args = '{32'h0, 32'h00FF8000, 32'h0, 32'h00010000, 32'h00020000};
        exp_stb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rsp = '{40'h3F90FF8000, 40'h3F90FF8000, 40'h0300010000, 40'h0700000000, 40'h0700000000};
        exp_card = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 5; i++) begin
            run_simple(cmds[i], args[i], 1'b1);
            checks++;
            if (obs_stb !== exp_stb[i] || obs_fail !== !exp_stb[i] || obs_early !== 1'b0) begin
                errors++; $display("FAIL init_seq%0d_strobe: got stb=%b fail=%b early=%b want stb=%b",
                                   i, obs_stb, obs_fail, obs_early, exp_stb[i]);
            end
            checks++;
            if (obs_rsps !== exp_rsp[i] || obs_card !== exp_card[i]) begin
                errors++; $display("FAIL init_seq%0d_rsps: got %h card=%0d want %h card=%0d",
                                   i, obs_rsps, obs_card, exp_rsp[i], exp_card[i]);
            end
            checks++;
            if (obs_busy1 !== 1'b1 || obs_busy3 !== 1'b0 || obs_after !== 1'b0) begin
                errors++; $display("FAIL init_seq%0d_busy: got busy1=%b busy3=%b after=%b want 1/0/0",
                                   i, obs_busy1, obs_busy3, obs_after);
            end
        end
        run_simple(6'd7, 32'h00010000, 1'b1);
        m_card = 2'd2; m_rsps = 40'h0700000000;
        checks++;
        if (obs_card !== 2'd2) begin
            errors++; $display("FAIL reselect_card: got %0d want 2", obs_card);
        end
    endtask

    task automatic test_cmd52_read;
        issue(6'd52, 32'h10002000, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr} !== {1'b1, 1'b0, 3'd1, 17'h00010}) begin
            errors++; $display("FAIL cmd52_rd_req: got stb=%b wr=%b func=%0d addr=%h want 1/0/1/00010",
                               o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o_rsps_stb !== 1'b0 || o_reg_stb !== 1'b0 || o_busy !== 1'b1) begin
                errors++; $display("FAIL cmd52_rd_wait%0d: got stb=%b regstb=%b busy=%b want 0/0/1",
                                   k, o_rsps_stb, o_reg_stb, o_busy);
            end
        end
        i_reg_ack = 1'b1; i_reg_data = 8'hA5;
        @(posedge clk); #1;
        i_reg_ack = 1'b0;
        checks++;
        if (o_rsps_stb !== 1'b1 || o_rsps !== 40'h34000010A5) begin
            errors++; $display("FAIL cmd52_rd_rsp: got stb=%b rsps=%h want 1/34000010a5", o_rsps_stb, o_rsps);
        end
        m_rsps = 40'h34000010A5;
        @(posedge clk); #1;
        checks++;
        if (o_rsps_stb !== 1'b0 || o_busy !== 1'b0 || o_rsps !== m_rsps) begin
            errors++; $display("FAIL cmd52_rd_after: got stb=%b busy=%b rsps=%h want 0/0/%h",
                               o_rsps_stb, o_busy, o_rsps, m_rsps);
        end
    endtask

    task automatic test_timeout_late_ack;
        issue(6'd52, 32'h9000405A, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({o_reg_stb, o_reg_wr, o_reg_func, o_reg_data} !== {1'b1, 1'b1, 3'd1, 8'h5A}) begin
            errors++; $display("FAIL timeout_req: got stb=%b wr=%b func=%0d data=%h want 1/1/1/5a",
                               o_reg_stb, o_reg_wr, o_reg_func, o_reg_data);
        end
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o_rsps_stb !== (k == 17)) begin
                errors++; $display("FAIL timeout_cycle%0d: got stb=%b want %b", k, o_rsps_stb, (k == 17));
            end
        end
        checks++;
        if (o_rsps !== 40'h3400001800) begin
            errors++; $display("FAIL timeout_rsps: got %h want 3400001800", o_rsps);
        end
        m_rsps = 40'h3400001800;
        i_reg_ack = 1'b1; i_reg_data = 8'hEE;
        @(posedge clk); #1;
        i_reg_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_rsps_stb !== 1'b0 || o_rsps_fail !== 1'b0 || o_rsps !== m_rsps || o_busy !== 1'b0) begin
                errors++; $display("FAIL late_ack%0d: got stb=%b fail=%b rsps=%h busy=%b want 0/0/%h/0",
                                   k, o_rsps_stb, o_rsps_fail, o_rsps, o_busy, m_rsps);
            end
            @(posedge clk); #1;
        end
        // ack arriving on the last wait cycle must still be honoured
        issue(6'd52, 32'h10002000, 1'b1);
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
        end
        i_reg_ack = 1'b1; i_reg_data = 8'h3C;
        @(posedge clk); #1;
        i_reg_ack = 1'b0;
        checks++;
        if (o_rsps_stb !== 1'b1 || o_rsps !== 40'h340000103C) begin
            errors++; $display("FAIL ack_at_timeout: got stb=%b rsps=%h want 1/340000103c", o_rsps_stb, o_rsps);
        end
        m_rsps = 40'h340000103C;
        @(posedge clk); #1;
    endtask

    task automatic test_crc_and_drop;
        run_simple(6'd3, 32'h0, 1'b0);
        checks++;
        if (obs_fail !== 1'b1 || obs_stb !== 1'b0 || obs_card !== 2'd2 || obs_rsps !== m_rsps) begin
            errors++; $display("FAIL crc_bad: got fail=%b stb=%b card=%0d rsps=%h want 1/0/2/%h",
                               obs_fail, obs_stb, obs_card, obs_rsps, m_rsps);
        end
        issue(6'd52, 32'h10002000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_cmd_stb = 1'b1; i_cmd = 6'd0; i_cmd_crc_good_stb = 1'b1;
        @(posedge clk); #1;
        i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
        checks++;
        if (o_cmd_drop !== 1'b1) begin
            errors++; $display("FAIL drop_pulse: got %b want 1", o_cmd_drop);
        end
        i_reg_ack = 1'b1; i_reg_data = 8'h77;
        @(posedge clk); #1;
        i_reg_ack = 1'b0;
        checks++;
        if (o_cmd_drop !== 1'b0 || o_rsps_stb !== 1'b1 || o_rsps !== 40'h3400001077 || o_card_state !== 2'd2) begin
            errors++; $display("FAIL drop_complete: got drop=%b stb=%b rsps=%h card=%0d want 0/1/3400001077/2",
                               o_cmd_drop, o_rsps_stb, o_rsps, o_card_state);
        end
        m_rsps = 40'h3400001077;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int bad;
        issue(6'd52, 32'h10002000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_card_state !== 2'd0 || o_reg_stb !== 1'b0 || o_rsps_stb !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got busy=%b card=%0d regstb=%b stb=%b want 0/0/0/0",
                               o_busy, o_card_state, o_reg_stb, o_rsps_stb);
        end
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (o_rsps_stb || o_rsps_fail || o_reg_stb) bad++;
        end
        rst = 1'b0;
        i_reg_ack = 1'b1; i_reg_data = 8'h11;
        @(posedge clk); #1;
        i_reg_ack = 1'b0;
        repeat (3) begin
            if (o_rsps_stb || o_rsps_fail || o_busy) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_mid_quiet: got %0d stray strobe cycles want 0", bad);
        end
        m_card = 2'd0; m_rsps = 40'd0;
        run_simple(6'd52, 32'h10002000, 1'b1);
        checks++;
        if (obs_fail !== 1'b1 || obs_stb !== 1'b0 || obs_regstb !== 1'b0 || obs_card !== 2'd0) begin
            errors++; $display("FAIL cmd52_init: got fail=%b stb=%b regstb=%b card=%0d want 1/0/0/0",
                               obs_fail, obs_stb, obs_regstb, obs_card);
        end
    endtask

    task automatic test_random;
        int          kind, r, d, seen;
        logic [5:0]  c;
        logic [31:0] a;
        logic        good;
        logic [39:0] rsp;
        logic [1:0]  nst;
        logic [7:0]  rdata;
        logic [39:0] exp_rsp;
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            if (r < 4) c = 6'd0;
            else if (r < 22) begin c = 6'd5; if ($urandom_range(0, 1) == 0) a[23:0] = 24'd0; end
            else if (r < 34) c = 6'd3;
            else if (r < 52) begin
                c = 6'd7;
                if (m_card == 2'd0 || $urandom_range(0, 3) != 0) a[31:16] = 16'h0001;
                else if (a[31:16] == 16'h0001) a[31:16] = 16'h0002;
            end
            else if (r < 85) begin
                c = 6'd52;
                a[30:28] = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
            end
            else begin
                c = 6'($urandom_range(0, 63));
                if (c == 6'd0 || c == 6'd3 || c == 6'd5 || c == 6'd7 || c == 6'd52) c = 6'd1;
            end
            good = ($urandom_range(0, 9) != 0);
            model_cmd(m_card, c, a, good, kind, rsp, nst);
            if (kind != 2) begin
                run_simple(c, a, good);
                if (kind == 0) m_rsps = rsp;
                m_card = nst;
                checks++;
                if (obs_stb !== (kind == 0) || obs_fail !== (kind == 1) || obs_rsps !== m_rsps ||
                    obs_card !== m_card || obs_busy3 !== 1'b0) begin
                    errors++; $display("FAIL rand%0d cmd%0d arg=%h: got stb=%b fail=%b rsps=%h card=%0d busy3=%b want %b/%b/%h/%0d/0",
                                       n, c, a, obs_stb, obs_fail, obs_rsps, obs_card, obs_busy3,
                                       (kind == 0), (kind == 1), m_rsps, m_card);
                end
            end else begin
                issue(c, a, good);
                @(posedge clk); #1;
                checks++;
                if ({o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr, o_reg_data} !==
                    {1'b1, a[31], a[30:28], a[25:9], a[7:0]}) begin
                    errors++; $display("FAIL rand%0d reg_req: got stb=%b wr=%b func=%0d addr=%h data=%h want arg=%h",
                                       n, o_reg_stb, o_reg_wr, o_reg_func, o_reg_addr, o_reg_data, a);
                end
                d = $urandom_range(1, 20);
                rdata = 8'($urandom);
                seen = 0;
                for (int k = 1; k <= 20 && seen == 0; k++) begin
                    @(posedge clk); #1;
                    i_reg_ack = 1'b0;
                    if (o_rsps_stb || o_rsps_fail) seen = k;
                    else if (k == d) begin i_reg_ack = 1'b1; i_reg_data = rdata; end
                end
                i_reg_ack = 1'b0;
                if (d <= 16) exp_rsp = {8'h34, 16'h0, 8'h10, (!a[31] || a[27]) ? rdata : a[7:0]};
                else         exp_rsp = 40'h3400001800;
                checks++;
                if (seen != ((d <= 16) ? d + 1 : 17) || o_rsps_stb !== 1'b1 || o_rsps !== exp_rsp) begin
                    errors++; $display("FAIL rand%0d reg_rsp d=%0d: got cycle=%0d stb=%b rsps=%h want cycle=%0d rsps=%h",
                                       n, d, seen, o_rsps_stb, o_rsps, (d <= 16) ? d + 1 : 17, exp_rsp);
                end
                m_rsps = exp_rsp;
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset;
        test_init_sequence;
        test_cmd52_read;
        test_timeout_late_ack;
        test_crc_and_drop;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdio_cmd_sequencer.md
# sdio_cmd_sequencer

Command-layer controller that sits directly above `sdio_device_phy` on the CMD line. It consumes each decoded command strobe from the PHY and tracks the card state (INIT/STBY/CMD). It executes CMD52 register accesses over a single-beat function register bus, then hands the PHY a 40-bit response or a fail (no-response) strobe. It is the only block that drives the PHY's response inputs.

## Interface
- `NUM_FUNCS`, 3'd1: number of I/O functions reported in the R4 response; CMD52 to a function number above this value is rejected.
- `OCR_VALUE`, 24'hFF8000: supported voltage window returned in R4.
- `RCA_VALUE`, 16'h0001: relative card address published by CMD3.
- `REG_TIMEOUT`, 8'd16: clocks to wait for `i_reg_ack` before aborting a CMD52.
- `clk` in 1: sequencer clock, the same clock as the PHY's `i_sdio_clk`. One clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `i_cmd_stb` in 1: one-cycle pulse; a command was received (from PHY `o_cmd_stb`).
- `i_cmd_crc_good_stb` in 1: asserted in the same cycle as `i_cmd_stb` when the CRC matched.
- `i_cmd` in 6: command index.
- `i_cmd_arg` in 32: command argument.
- `o_rsps_stb` out 1: one-cycle pulse; response valid.
- `o_rsps` out 40: response word, MSB first: start bit, direction bit, index, payload, with CRC7 and end bit excluded.
- `o_rsps_len` out 8: always 8'd40.
- `o_rsps_fail` out 1: one-cycle pulse; PHY aborts and sends no response.
- `o_reg_stb` out 1: one-cycle register request.
- `o_reg_wr` out 1: 1 = write.
- `o_reg_func` out 3: function number.
- `o_reg_addr` out 17: register address.
- `o_reg_data` out 8: write data.
- `i_reg_ack` in 1: one-cycle completion.
- `i_reg_data` in 8: read data, valid with `i_reg_ack`.
- `o_card_state` out 2: 0 INIT, 1 STBY, 2 CMD.
- `o_busy` out 1: high whenever the FSM is not in IDLE.
- `o_cmd_drop` out 1: one-cycle pulse; an `i_cmd_stb` arrived while busy.

## Operation
- FSM states: IDLE, DECODE, REG_REQ, REG_WAIT, RESPOND.
- IDLE, on `i_cmd_stb`: latch the index and argument, then go to DECODE. If `i_cmd_crc_good_stb` is low, pulse `o_rsps_fail` the next cycle, return to IDLE, and leave card state unchanged.
- DECODE, per command, with R = {2'b00, index[5:0], payload[31:0]}:
  - CMD0: card state goes to INIT; `o_rsps_fail` pulses.
  - CMD5 (any state): R4 with index field 6'h3F. Payload = {1'b1 (C), NUM_FUNCS, 1'b0 (MP), 3'b0, OCR_VALUE}.
  - CMD5, when arg[23:0] != 0 and state is INIT: card state goes to STBY.
  - CMD3, valid in STBY or CMD: R6 with payload {RCA_VALUE, 16'h0000}. State unchanged. Rejected in INIT.
  - CMD7 with arg[31:16] == RCA_VALUE, valid in STBY or CMD: R1 with payload 32'h0; card state goes to CMD.
  - CMD7 with any other RCA: card state goes to STBY; `o_rsps_fail` pulses.
  - CMD52, valid only in CMD: go to REG_REQ.
  - Any other index, or an index not valid in the current state: `o_rsps_fail` pulses.
- CMD52 argument fields: [31] write, [30:28] function, [27] RAW, [25:9] address, [7:0] data.
  - If the function number exceeds NUM_FUNCS: respond R5 with flags 8'h12 and data 0, with no bus access.
- REG_REQ: pulse `o_reg_stb` with the fields above, then go to REG_WAIT and clear the timeout counter.
- REG_WAIT, on `i_reg_ack`:
  - Response data = `i_reg_data` for a read or for RAW; otherwise the write data.
  - Flags = 8'h10 (IO_CURRENT_STATE = CMD).
- REG_WAIT, when the counter reaches REG_TIMEOUT with no ack: R5 with flags 8'h18 (ERROR set) and data 0.
- R5 payload = {16'h0, flags, data}.
- RESPOND: drive `o_rsps` and pulse `o_rsps_stb` for one cycle, then return to IDLE.
- `o_cmd_drop`: any `i_cmd_stb` outside IDLE is ignored and pulses `o_cmd_drop`.
- Late ack: an `i_reg_ack` arriving after the timeout, or outside REG_WAIT, is ignored.

## Timing
- Reset values: `o_rsps` = 0, `o_rsps_len` = 40, `o_card_state` = INIT, FSM = IDLE. All strobes, `o_reg_*` and `o_busy` = 0.
- Reset mid-operation: return immediately to IDLE with no strobe emitted. Any outstanding register request is abandoned.
- Latency, non-register commands: `i_cmd_stb` at cycle N gives `o_rsps_stb` or `o_rsps_fail` at cycle N+2.
- Latency, CMD52: `o_reg_stb` at N+2. With `i_reg_ack` at cycle M, `o_rsps_stb` follows at M+1.
- Ack in the same cycle as the timeout: the ack wins.
- `o_rsps` and `o_rsps_len` remain stable after `o_rsps_stb` until the next response.
- `o_rsps_stb` and `o_rsps_fail` are mutually exclusive; each pulses at most once per accepted command.
- `o_busy` is high from N+1 until the cycle after the outcome strobe.

## Test plan
- Reset, then CMD5 arg 0x00000000 → `o_rsps` = 40'h3F_9_0FF8000 (C=1, NUM_FUNCS=1), state stays INIT. Then CMD5 arg 0x00FF8000 → same response, state = STBY.
- CMD3 in STBY → `o_rsps` = 40'h03_0001_0000. CMD7 arg 0x00010000 → R1 40'h07_00000000, state = CMD. CMD7 arg 0x00020000 → fail pulse, state = STBY.
- In CMD: CMD52 read, function 1, address 0x00010, with ack after 3 cycles returning 8'hA5 → `o_reg_stb` with wr=0, `o_reg_addr` = 0x10. Then `o_rsps` = 40'h34_0000_10A5, exactly one cycle after the ack.
- CMD52 write, function 1, data 0x5A, with no ack → `o_rsps` flags 8'h18, data 0, 16+1 cycles after `o_reg_stb`. Drive a late ack afterwards → no effect.
- Command with `i_cmd_crc_good_stb` = 0 → `o_rsps_fail` at N+2 and card state unchanged. An `i_cmd_stb` during REG_WAIT → `o_cmd_drop` pulses and the CMD52 still completes.
- Assert `rst` during REG_WAIT → no strobes, state = INIT, `o_busy` = 0 immediately. CMD52 in INIT → fail pulse.
